// File: rtl/mac_learning_lut.sv
// Learns source MAC to port bindings and resolves each packet's destination port vector.
// Latency: lookup_done follows eth_done by exactly 2 cycles; one header accepted per cycle.
// Backpressure: none; the block always accepts eth_done and always produces a result.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   dst_mac, src_mac      parsed MACs, first wire byte in [7:0] (bit 0 = group bit)
//   src_port              one-hot ingress port (even bits MAC ports, odd bits CPU ports)
//   eth_done              one-cycle strobe qualifying the three inputs above
//   dst_ports             resolved output port vector, 0 when lookup_done is low
//   lookup_done           one-cycle strobe qualifying dst_ports/lut_hit/lut_miss
//   lut_hit, lut_miss     exclusive result flags, pulse only with lookup_done
module mac_learning_lut #(
   parameter int                    NUM_QUEUES     = 8,
   parameter int                    LUT_DEPTH      = 16,
   parameter int                    LUT_DEPTH_BITS = 4,
   parameter logic [NUM_QUEUES-1:0] FLOOD_PORTS    = 8'h55
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [47:0]           dst_mac,
   input  logic [47:0]           src_mac,
   input  logic [NUM_QUEUES-1:0] src_port,
   input  logic                  eth_done,
   output logic [NUM_QUEUES-1:0] dst_ports,
   output logic                  lookup_done,
   output logic                  lut_hit,
   output logic                  lut_miss
);

   // ------------------------------------------------------------------
   // Table storage. Only the valid bits need a reset; MAC/port contents
   // are ignored until their valid bit is set.
   // ------------------------------------------------------------------
   logic [LUT_DEPTH-1:0]      tbl_vld;
   logic [47:0]               tbl_mac  [LUT_DEPTH];
   logic [NUM_QUEUES-1:0]     tbl_port [LUT_DEPTH];
   logic [LUT_DEPTH_BITS-1:0] lut_ptr;

   // ------------------------------------------------------------------
   // Stage-1 registers (packet captured on the edge after eth_done)
   // ------------------------------------------------------------------
   logic                      s1_vld;
   logic                      s1_dst_mcast;
   logic [47:0]               s1_src_mac;
   logic [NUM_QUEUES-1:0]     s1_src_port;
   logic                      s1_dst_hit;
   logic [LUT_DEPTH_BITS-1:0] s1_dst_idx;
   logic                      s1_src_hit;
   logic [LUT_DEPTH_BITS-1:0] s1_src_idx;

   // ------------------------------------------------------------------
   // Stage-2 learn write, computed from the stage-1 registers. It lands
   // in the table on the same edge that the next packet's stage-1
   // compare results are captured.
   // ------------------------------------------------------------------
   logic                      wr_en;
   logic [LUT_DEPTH_BITS-1:0] wr_addr;

   always_comb begin
      // A group-bit source is never a legitimate station address.
      wr_en   = s1_vld && !s1_src_mac[0];
      wr_addr = s1_src_hit ? s1_src_idx : lut_ptr;
   end

   // ------------------------------------------------------------------
   // Stage-1 associative compare against the table as it will look after
   // the pending learn write. Substituting the pending write per entry
   // makes the forwarding win over stale contents, covers an eviction of
   // a matching entry, and prevents duplicate allocation when the same
   // source arrives on consecutive cycles. Descending scan so the lowest
   // matching index wins.
   // ------------------------------------------------------------------
   logic                      dst_hit_c;
   logic [LUT_DEPTH_BITS-1:0] dst_idx_c;
   logic                      src_hit_c;
   logic [LUT_DEPTH_BITS-1:0] src_idx_c;

   always_comb begin
      dst_hit_c = 1'b0;
      dst_idx_c = '0;
      src_hit_c = 1'b0;
      src_idx_c = '0;
      for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
         logic        eff_vld;
         logic [47:0] eff_mac;
         if (wr_en && (wr_addr == LUT_DEPTH_BITS'(i))) begin
            eff_vld = 1'b1;
            eff_mac = s1_src_mac;
         end else begin
            eff_vld = tbl_vld[i];
            eff_mac = tbl_mac[i];
         end
         if (eff_vld && (eff_mac == dst_mac)) begin
            dst_hit_c = 1'b1;
            dst_idx_c = LUT_DEPTH_BITS'(i);
         end
         if (eff_vld && (eff_mac == src_mac)) begin
            src_hit_c = 1'b1;
            src_idx_c = LUT_DEPTH_BITS'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld       <= 1'b0;
         s1_dst_mcast <= 1'b0;
         s1_src_mac   <= '0;
         s1_src_port  <= '0;
         s1_dst_hit   <= 1'b0;
         s1_dst_idx   <= '0;
         s1_src_hit   <= 1'b0;
         s1_src_idx   <= '0;
      end else begin
         s1_vld       <= eth_done;
         s1_dst_mcast <= dst_mac[0];
         s1_src_mac   <= src_mac;
         s1_src_port  <= src_port;
         s1_dst_hit   <= dst_hit_c;
         s1_dst_idx   <= dst_idx_c;
         s1_src_hit   <= src_hit_c;
         s1_src_idx   <= src_idx_c;
      end
   end

   // ------------------------------------------------------------------
   // Stage-2 destination resolution. The table read here is already
   // coherent: it holds every write up to the previous packet, which is
   // exactly the view the stage-1 compare used.
   // ------------------------------------------------------------------
   logic [NUM_QUEUES-1:0] flood_vec;
   logic [NUM_QUEUES-1:0] entry_port;
   logic [NUM_QUEUES-1:0] ports_c;
   logic                  hit_c;
   logic                  miss_c;

   always_comb begin
      flood_vec  = FLOOD_PORTS & ~s1_src_port;
      entry_port = tbl_port[s1_dst_idx];
      ports_c    = '0;
      hit_c      = 1'b0;
      miss_c     = 1'b0;
      if (s1_vld) begin
         if (s1_dst_mcast) begin
            ports_c = flood_vec;
            miss_c  = 1'b1;
         end else if (s1_dst_hit) begin
            hit_c = 1'b1;
            // Destination lives on the ingress port: drop, never hairpin.
            ports_c = (entry_port == s1_src_port) ? '0 : entry_port;
         end else begin
            ports_c = flood_vec;
            miss_c  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dst_ports   <= '0;
         lookup_done <= 1'b0;
         lut_hit     <= 1'b0;
         lut_miss    <= 1'b0;
      end else begin
         dst_ports   <= ports_c;
         lookup_done <= s1_vld;
         lut_hit     <= hit_c;
         lut_miss    <= miss_c;
      end
   end

   // ------------------------------------------------------------------
   // Learning. A source hit refreshes the port in place; a miss allocates
   // at the FIFO replacement pointer, evicting the oldest allocation once
   // the table has wrapped.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         tbl_vld <= '0;
         lut_ptr <= '0;
      end else if (wr_en) begin
         tbl_vld[wr_addr] <= 1'b1;
         if (!s1_src_hit) begin
            lut_ptr <= (lut_ptr == LUT_DEPTH_BITS'(LUT_DEPTH - 1)) ? '0 : lut_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         tbl_mac[wr_addr]  <= s1_src_mac;
         tbl_port[wr_addr] <= s1_src_port;
      end
   end

endmodule

// File: tb/tb_mac_learning_lut.sv
module tb_mac_learning_lut;

   logic        clk;
   logic        reset;
   logic [47:0] dst_mac;
   logic [47:0] src_mac;
   logic [7:0]  src_port;
   logic        eth_done;
   logic [7:0]  dst_ports;
   logic        lookup_done;
   logic        lut_hit;
   logic        lut_miss;

   mac_learning_lut dut (
      .clk        (clk),
      .reset      (reset),
      .dst_mac    (dst_mac),
      .src_mac    (src_mac),
      .src_port   (src_port),
      .eth_done   (eth_done),
      .dst_ports  (dst_ports),
      .lookup_done(lookup_done),
      .lut_hit    (lut_hit),
      .lut_miss   (lut_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unicast addresses keep bit 0 (group bit of the first wire byte) clear.
   localparam logic [47:0] MAC_AA = 48'hAA00_0000_0002;
   localparam logic [47:0] MAC_11 = 48'h1100_0000_0002;
   localparam logic [47:0] MAC_22 = 48'h2200_0000_0002;
   localparam logic [47:0] MAC_33 = 48'h3300_0000_0002;
   localparam logic [47:0] MAC_44 = 48'h4400_0000_0002;
   localparam logic [47:0] MAC_55 = 48'h5500_0000_0002;
   localparam logic [47:0] MAC_UNK = 48'hDD00_0000_0002;
   localparam logic [47:0] MAC_BC = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] MAC_MC_SRC = 48'h0000_5E00_0001;

   typedef struct {
      logic [7:0] ports;
      logic       hit;
      logic       miss;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard whenever the DUT presents a result and
   // checks idle outputs otherwise.
   always @(negedge clk) begin
      if (!reset) begin
         if (lookup_done) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_lookup_done cyc=%0d dst_ports=%h", cyc, dst_ports);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               n_cmp++;
               if (dst_ports !== e.ports || lut_hit !== e.hit || lut_miss !== e.miss) begin
                  n_err++;
                  $display("FAIL result cyc=%0d got ports=%h hit=%b miss=%b want ports=%h hit=%b miss=%b",
                           cyc, dst_ports, lut_hit, lut_miss, e.ports, e.hit, e.miss);
               end
               n_cmp++;
               if (cyc != e.cyc + 2) begin
                  n_err++;
                  $display("FAIL latency got cyc=%0d want cyc=%0d", cyc, e.cyc + 2);
               end
            end
         end else begin
            n_cmp++;
            if (dst_ports !== 8'h00 || lut_hit !== 1'b0 || lut_miss !== 1'b0) begin
               n_err++;
               $display("FAIL idle_outputs cyc=%0d got ports=%h hit=%b miss=%b want 00/0/0",
                        cyc, dst_ports, lut_hit, lut_miss);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [47:0] d, input logic [47:0] s, input logic [7:0] p,
                       input logic [7:0] ep, input logic eh, input logic em);
      @(negedge clk);
      dst_mac  = d;
      src_mac  = s;
      src_port = p;
      eth_done = 1'b1;
      sb_q.push_back('{ports: ep, hit: eh, miss: em, cyc: cyc});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         eth_done = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      eth_done = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic int count_mac(input logic [47:0] m);
      int c = 0;
      for (int i = 0; i < 16; i++)
         if (dut.tbl_vld[i] && dut.tbl_mac[i] == m) c++;
      return c;
   endfunction

   initial begin
      reset    = 1'b1;
      eth_done = 1'b0;
      dst_mac  = '0;
      src_mac  = '0;
      src_port = '0;
      do_reset();

      // Reset state
      check("reset_lookup_done", 64'(lookup_done), 64'h0);
      check("reset_dst_ports", 64'(dst_ports), 64'h0);
      check("reset_hit_miss", 64'({lut_hit, lut_miss}), 64'h0);
      check("reset_tbl_vld", 64'(dut.tbl_vld), 64'h0);
      check("reset_ptr", 64'(dut.lut_ptr), 64'h0);

      // 1: first packet floods and learns 11 at entry 0
      send(MAC_AA, MAC_11, 8'h01, 8'h54, 1'b0, 1'b1);
      idle(4);
      check("t1_entry0_mac", 64'(dut.tbl_mac[0]), 64'(MAC_11));
      check("t1_entry0_port", 64'(dut.tbl_port[0]), 64'h01);

      // 2: unicast hit, learn 22 at entry 1, then hairpin drop
      send(MAC_11, MAC_22, 8'h04, 8'h01, 1'b1, 1'b0);
      idle(4);
      check("t2_entry1_mac", 64'(dut.tbl_mac[1]), 64'(MAC_22));
      check("t2_entry1_port", 64'(dut.tbl_port[1]), 64'h04);
      send(MAC_11, MAC_11, 8'h01, 8'h00, 1'b1, 1'b0);
      idle(4);

      // 3: broadcast floods excluding ingress; 22 moves to port 0x10
      send(MAC_BC, MAC_22, 8'h10, 8'h45, 1'b0, 1'b1);
      send(MAC_22, MAC_11, 8'h01, 8'h10, 1'b1, 1'b0);
      idle(4);
      check("t3_ptr_unchanged", 64'(dut.lut_ptr), 64'h2);

      // 4: 17 sources back-to-back wrap the FIFO pointer
      do_reset();
      for (int i = 0; i < 17; i++)
         send(MAC_UNK, 48'hC000_0000_0000 | (48'(i) << 8), 8'h01, 8'h54, 1'b0, 1'b1);
      idle(4);
      check("t4_ptr", 64'(dut.lut_ptr), 64'h1);
      check("t4_entry0_mac", 64'(dut.tbl_mac[0]), 64'hC000_0000_1000);
      send(48'hC000_0000_0000, MAC_MC_SRC, 8'h04, 8'h51, 1'b0, 1'b1);
      send(48'hC000_0000_0100, MAC_MC_SRC, 8'h04, 8'h01, 1'b1, 1'b0);
      idle(4);
      check("t4_mc_src_not_learned", 64'(dut.lut_ptr), 64'h1);

      // 5: learn-to-lookup forwarding and no duplicate allocation
      send(MAC_AA, MAC_33, 8'h04, 8'h51, 1'b0, 1'b1);
      send(MAC_33, MAC_44, 8'h01, 8'h04, 1'b1, 1'b0);
      send(MAC_AA, MAC_33, 8'h04, 8'h51, 1'b0, 1'b1);
      send(MAC_AA, MAC_33, 8'h04, 8'h51, 1'b0, 1'b1);
      send(MAC_AA, MAC_33, 8'h04, 8'h51, 1'b0, 1'b1);
      idle(4);
      check("t5_count_33", 64'(count_mac(MAC_33)), 64'h1);
      check("t5_ptr", 64'(dut.lut_ptr), 64'h3);

      // 6: reset one cycle after eth_done discards the packet
      @(negedge clk);
      dst_mac  = MAC_AA;
      src_mac  = MAC_55;
      src_port = 8'h01;
      eth_done = 1'b1;
      @(negedge clk);
      eth_done = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle(3);
      check("t6_tbl_vld", 64'(dut.tbl_vld), 64'h0);
      check("t6_ptr", 64'(dut.lut_ptr), 64'h0);
      send(MAC_33, MAC_22, 8'h04, 8'h51, 1'b0, 1'b1);
      idle(1);

      // Drain with a bound
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout got %0d pending want 0", sb_q.size());
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
